// File: rtl/ctrl_panel_avmm_arbiter.sv
// Two-master Avalon-MM arbiter sharing one control-panel slave.
// Round-robin on ties, bounded grant length, and fixed 1-cycle read
// return routed to the master that issued the read.
module ctrl_panel_avmm_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_GRANT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic [1:0]        grant
);

  // One spare count value so the "last transfer" compare never wraps.
  localparam int CNT_W = $clog2(MAX_GRANT + 2);
  localparam logic [CNT_W-1:0] MAXG = CNT_W'(MAX_GRANT);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t           r_state, w_next;
  logic             r_last_owner;   // 0 = M0, 1 = M1
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_pend;
  logic             r_rd_tag;       // master that issued the pending read

  logic w_req0, w_req1;
  logic w_owner;      // index of current owner (valid when not IDLE)
  logic w_own_req;
  logic w_accept;
  logic w_last;       // accepted transfer completes this grant's quota

  assign w_req0    = m0_read | m0_write;
  assign w_req1    = m1_read | m1_write;
  assign w_owner   = (r_state == GNT1);
  assign w_own_req = (r_state == GNT0) ? w_req0 :
                     (r_state == GNT1) ? w_req1 : 1'b0;
  assign w_accept  = w_own_req & ~s_waitrequest;
  assign w_last    = w_accept & (r_cnt >= MAXG - 1'b1);
  assign grant     = {r_state == GNT1, r_state == GNT0};

  // Next-state: round-robin from IDLE, hand-over on drop or quota.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last_owner ? GNT0 : GNT1;
        else if (w_req0)      w_next = GNT0;
        else if (w_req1)      w_next = GNT1;
      end
      GNT0: begin
        if (!w_req0)               w_next = w_req1 ? GNT1 : IDLE;
        else if (w_last && w_req1) w_next = GNT1;
      end
      GNT1: begin
        if (!w_req1)               w_next = w_req0 ? GNT0 : IDLE;
        else if (w_last && w_req0) w_next = GNT0;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, grant counter and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
        if (w_next == GNT0) r_last_owner <= 1'b0;
        if (w_next == GNT1) r_last_owner <= 1'b1;
      end else if (w_accept && (r_cnt != MAXG)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Remember who issued an accepted read so its data returns there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_tag  <= 1'b0;
    end else begin
      r_rd_pend <= w_accept & s_read;
      if (w_accept && s_read) r_rd_tag <= w_owner;
    end
  end

  // Combinational forwarding of the owner to the slave; others stall.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  // Read return steering, independent of the current grant.
  always_comb begin
    m0_readdatavalid = r_rd_pend & ~r_rd_tag;
    m1_readdatavalid = r_rd_pend &  r_rd_tag;
    m0_readdata      = m0_readdatavalid ? s_readdata : '0;
    m1_readdata      = m1_readdatavalid ? s_readdata : '0;
  end

endmodule
